// File: rtl/tcdm_interconnect_pkg.sv
// rtl/tcdm_interconnect_pkg.sv - shared helpers for the TCDM interconnect
package tcdm_interconnect_pkg;

    // Index width for a population of num ports; a single port still gets one bit.
    function automatic int unsigned idx_width(input int unsigned num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

endpackage

// File: rtl/tcdm_bank_rr_arb_if.sv
// rtl/tcdm_bank_rr_arb_if.sv - master-side and bank-side signals of one bank arbiter
interface tcdm_bank_rr_arb_if #(
    parameter int unsigned NumMaster     = 32,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32
);
    logic [NumMaster-1:0]                   req_i;
    logic [NumMaster-1:0]                   gnt_o;
    logic [NumMaster-1:0][ReqDataWidth-1:0] data_i;
    logic [RespDataWidth-1:0]               rdata_o;
    logic                                   req_o;
    logic                                   gnt_i;
    logic [ReqDataWidth-1:0]                data_o;
    logic [RespDataWidth-1:0]               rdata_i;

    modport slave (
        input  req_i, data_i, gnt_i, rdata_i,
        output gnt_o, rdata_o, req_o, data_o
    );

    modport master (
        output req_i, data_i, gnt_i, rdata_i,
        input  gnt_o, rdata_o, req_o, data_o
    );
endinterface

// File: rtl/lic_rr_pick.sv
// rtl/lic_rr_pick.sv - combinational rotating-priority pick starting at ptr_i
module lic_rr_pick
    import tcdm_interconnect_pkg::*;
#(
    parameter int unsigned NumReq   = 4,
    parameter int unsigned IdxWidth = idx_width(NumReq)
) (
    input  logic [NumReq-1:0]   req_i,
    input  logic [IdxWidth-1:0] ptr_i,
    output logic [IdxWidth-1:0] idx_o,
    output logic                vld_o
);
    int unsigned          pos;
    logic [IdxWidth-1:0]  pos_idx;

    always_comb begin
        idx_o   = '0;
        vld_o   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            // Explicit wrap keeps the scan correct for non-power-of-two port counts.
            pos = 32'(ptr_i) + k;
            if (pos >= NumReq) begin
                pos = pos - NumReq;
            end
            pos_idx = pos[IdxWidth-1:0];
            if (!vld_o && req_i[pos_idx]) begin
                vld_o = 1'b1;
                idx_o = pos_idx;
            end
        end
    end
endmodule

// File: rtl/tcdm_bank_rr_arb.sv
// rtl/tcdm_bank_rr_arb.sv - round-robin arbiter of many masters onto one TCDM bank
module tcdm_bank_rr_arb
    import tcdm_interconnect_pkg::*;
#(
    parameter int unsigned NumMaster     = 32,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32,
    parameter bit          LockOnStall   = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    tcdm_bank_rr_arb_if.slave bus
);
    localparam int unsigned IdxW = idx_width(NumMaster);

    logic [ReqDataWidth-1:0]  data_sel;
    logic [RespDataWidth-1:0] rdata;
    logic [NumMaster-1:0]     gnt;
    logic                     req_any;

    // Responses are routed master-side, so read data is a pure broadcast.
    assign rdata       = bus.rdata_i;
    assign bus.rdata_o = rdata;
    assign bus.req_o   = req_any;
    assign bus.data_o  = data_sel;
    assign bus.gnt_o   = gnt;

    if (NumMaster == 1) begin : g_single
        assign req_any  = bus.req_i[0];
        assign gnt      = bus.req_i[0] & bus.gnt_i;
        assign data_sel = bus.req_i[0] ? bus.data_i[0] : '0;
    end else begin : g_multi
        logic [IdxW-1:0] rr_q;
        logic [IdxW-1:0] pick_idx;
        logic [IdxW-1:0] winner;
        logic            pick_vld;
        logic            hs;

        lic_rr_pick #(
            .NumReq   (NumMaster),
            .IdxWidth (IdxW)
        ) i_pick (
            .req_i (bus.req_i),
            .ptr_i (rr_q),
            .idx_o (pick_idx),
            .vld_o (pick_vld)
        );

        assign req_any  = |bus.req_i;
        assign hs       = req_any & bus.gnt_i;
        assign data_sel = pick_vld ? bus.data_i[winner] : '0;

        always_comb begin
            gnt = '0;
            if (hs) begin
                gnt[winner] = 1'b1;
            end
        end

        if (LockOnStall) begin : g_lock
            logic            lock_vld_q;
            logic [IdxW-1:0] lock_idx_q;

            // A stalled winner keeps the bank until it is granted or withdraws.
            assign winner = (lock_vld_q && bus.req_i[lock_idx_q]) ? lock_idx_q : pick_idx;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    lock_vld_q <= 1'b0;
                    lock_idx_q <= '0;
                end else if (hs || !req_any) begin
                    lock_vld_q <= 1'b0;
                end else begin
                    lock_vld_q <= 1'b1;
                    lock_idx_q <= winner;
                end
            end
        end else begin : g_nolock
            assign winner = pick_idx;
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rr_q <= '0;
            end else if (hs) begin
                rr_q <= (winner == IdxW'(NumMaster - 1)) ? '0 : winner + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tcdm_bank_rr_arb.sv
// tb/tb_tcdm_bank_rr_arb.sv - directed self-checking bench for tcdm_bank_rr_arb
module tb_tcdm_bank_rr_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tcdm_bank_rr_arb_if #(.NumMaster(4), .ReqDataWidth(32), .RespDataWidth(32)) bus4 ();
    tcdm_bank_rr_arb_if #(.NumMaster(3), .ReqDataWidth(32), .RespDataWidth(32)) bus3 ();

    tcdm_bank_rr_arb #(
        .NumMaster(4), .ReqDataWidth(32), .RespDataWidth(32), .LockOnStall(1'b1)
    ) dut4 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus4)
    );

    tcdm_bank_rr_arb #(
        .NumMaster(3), .ReqDataWidth(32), .RespDataWidth(32), .LockOnStall(1'b1)
    ) dut3 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus3)
    );

    int nvec = 0;
    int errs = 0;
    int stepno = 0;
    logic [3:0][31:0] dat4;
    logic [2:0][31:0] dat3;

    // Model state: next index to favour, and the stalled master being held.
    int m_rr[2], m_lv[2], m_li[2];
    int n_rr[2], n_lv[2], n_li[2];
    int m_n[2] = '{4, 3};

    task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (step %0d)", nm, act, exp, stepno);
        end
    endtask

    function automatic int model_win(input int d, input logic [3:0] req);
        if (m_lv[d] != 0 && req[m_li[d]]) return m_li[d];
        for (int k = 0; k < m_n[d]; k++) begin
            if (req[(m_rr[d] + k) % m_n[d]]) return (m_rr[d] + k) % m_n[d];
        end
        return -1;
    endfunction

    task automatic check_one(input int d, input logic [3:0] req, input logic g,
                             input logic [3:0][31:0] dat, input logic [31:0] rdi,
                             input logic ro, input logic [3:0] go,
                             input logic [31:0] dout, input logic [31:0] rdo);
        int w;
        logic [3:0] eg;
        if (rst) begin
            m_rr[d] = 0; m_lv[d] = 0; m_li[d] = 0;
        end
        w  = model_win(d, req);
        eg = (w >= 0 && g) ? 4'(1 << w) : 4'b0;
        lit($sformatf("dut%0d req_o", m_n[d]), 64'(ro), 64'(req != 0));
        lit($sformatf("dut%0d gnt_o", m_n[d]), 64'(go), 64'(eg));
        lit($sformatf("dut%0d data_o", m_n[d]), 64'(dout), (w >= 0) ? 64'(dat[w]) : 64'd0);
        lit($sformatf("dut%0d rdata_o", m_n[d]), 64'(rdo), 64'(rdi));
        n_rr[d] = m_rr[d]; n_lv[d] = m_lv[d]; n_li[d] = m_li[d];
        if (rst) begin
            n_rr[d] = 0; n_lv[d] = 0; n_li[d] = 0;
        end else if (w >= 0 && g) begin
            n_rr[d] = (w + 1) % m_n[d];
            n_lv[d] = 0;
        end else if (w >= 0) begin
            n_lv[d] = 1;
            n_li[d] = w;
        end else begin
            n_lv[d] = 0;
        end
    endtask

    always begin
        @(negedge clk);
        check_one(0, bus4.req_i, bus4.gnt_i, dat4, bus4.rdata_i,
                  bus4.req_o, bus4.gnt_o, bus4.data_o, bus4.rdata_o);
        check_one(1, {1'b0, bus3.req_i}, bus3.gnt_i, {32'h0, dat3}, bus3.rdata_i,
                  bus3.req_o, {1'b0, bus3.gnt_o}, bus3.data_o, bus3.rdata_o);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_rr[d] = 0; m_lv[d] = 0; m_li[d] = 0;
            end else begin
                m_rr[d] = n_rr[d]; m_lv[d] = n_lv[d]; m_li[d] = n_li[d];
            end
        end
    end

    task automatic step(input logic r, input logic [3:0] q4, input logic g4,
                        input logic [2:0] q3, input logic g3);
        @(posedge clk);
        #1;
        stepno++;
        rst = r;
        for (int i = 0; i < 4; i++) dat4[i] = {8'hD4, 8'(i), 16'(stepno)};
        for (int i = 0; i < 3; i++) dat3[i] = {8'hD3, 8'(i), 16'(stepno)};
        bus4.data_i  = dat4;
        bus3.data_i  = dat3;
        bus4.req_i   = q4;
        bus4.gnt_i   = g4;
        bus3.req_i   = q3;
        bus3.gnt_i   = g3;
        bus4.rdata_i = $urandom;
        bus3.rdata_i = $urandom;
        #2;
    endtask

    task automatic step4(input logic r, input logic [3:0] q4, input logic g4);
        step(r, q4, g4, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    endtask

    logic [3:0] seq4[8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                            4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [2:0] seq3[4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_rr[d] = 0; m_lv[d] = 0; m_li[d] = 0;
            n_rr[d] = 0; n_lv[d] = 0; n_li[d] = 0;
        end
        dat4 = '0;
        dat3 = '0;
        bus4.req_i = '0; bus4.gnt_i = 1'b0; bus4.data_i = '0; bus4.rdata_i = '0;
        bus3.req_i = '0; bus3.gnt_i = 1'b0; bus3.data_i = '0; bus3.rdata_i = '0;

        step(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);
        lit("reset req_o", 64'(bus4.req_o), 64'd0);
        lit("reset gnt_o", 64'(bus4.gnt_o), 64'd0);
        lit("reset data_o", 64'(bus4.data_o), 64'd0);

        // Full contention: one grant per master per round, also with 3 masters.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b1111, 1'b1, (i < 4) ? 3'b111 : 3'b000, 1'b1);
            lit($sformatf("rr4 grant %0d", i), 64'(bus4.gnt_o), 64'(seq4[i]));
            if (i < 4) lit($sformatf("rr3 grant %0d", i), 64'(bus3.gnt_o), 64'(seq3[i]));
        end

        step4(1'b0, 4'b1111, 1'b1);
        lit("advance a", 64'(bus4.gnt_o), 64'b0001);
        step4(1'b0, 4'b1111, 1'b1);
        lit("advance b", 64'(bus4.gnt_o), 64'b0010);
        step4(1'b0, 4'b0011, 1'b1);
        lit("rr2 wrap pick", 64'(bus4.gnt_o), 64'b0001);
        step4(1'b0, 4'b0011, 1'b1);
        lit("rr1 pick", 64'(bus4.gnt_o), 64'b0010);

        step4(1'b0, 4'b0001, 1'b1);
        lit("set rr1", 64'(bus4.gnt_o), 64'b0001);
        for (int i = 0; i < 3; i++) begin
            step4(1'b0, 4'b0110, 1'b0);
            lit($sformatf("stall data %0d", i), 64'(bus4.data_o), 64'(dat4[1]));
            lit($sformatf("stall gnt %0d", i), 64'(bus4.gnt_o), 64'd0);
        end
        step4(1'b0, 4'b0110, 1'b1);
        lit("stall release data", 64'(bus4.data_o), 64'(dat4[1]));
        lit("stall release gnt", 64'(bus4.gnt_o), 64'b0010);

        step4(1'b0, 4'b0010, 1'b0);
        step4(1'b0, 4'b0110, 1'b0);
        lit("lock beats rr", 64'(bus4.data_o), 64'(dat4[1]));
        step4(1'b0, 4'b0100, 1'b0);
        lit("withdraw data", 64'(bus4.data_o), 64'(dat4[2]));
        step4(1'b0, 4'b0100, 1'b1);
        lit("withdraw gnt", 64'(bus4.gnt_o), 64'b0100);
        step4(1'b0, 4'b0001, 1'b0);
        step4(1'b0, 4'b1001, 1'b0);
        lit("lock0 over rr3", 64'(bus4.data_o), 64'(dat4[0]));
        step4(1'b0, 4'b1001, 1'b1);
        lit("lock0 gnt", 64'(bus4.gnt_o), 64'b0001);

        step4(1'b0, 4'b1000, 1'b0);
        lit("lock3 data", 64'(bus4.data_o), 64'(dat4[3]));
        step4(1'b1, 4'b1001, 1'b0);
        lit("reset drops lock", 64'(bus4.data_o), 64'(dat4[0]));
        step4(1'b0, 4'b1001, 1'b1);
        lit("post reset first", 64'(bus4.gnt_o), 64'b0001);
        step4(1'b0, 4'b1001, 1'b1);
        lit("post reset second", 64'(bus4.gnt_o), 64'b1000);

        step4(1'b0, 4'b0000, 1'b1);
        lit("idle gnt", 64'(bus4.gnt_o), 64'd0);
        lit("idle data", 64'(bus4.data_o), 64'd0);

        for (int i = 0; i < 40; i++) begin
            step4(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
